demux_1_to_4: RTL and testbench
===============================

# demux_1_to_4

Packet-aware 1-to-4 stream demultiplexer, the distributing counterpart to the 4-to-1 mux: one valid/ready input stream is steered to one of four output lanes. The lane is chosen by `in_sel` on the first beat of a packet and held until the beat with `in_last`. Each lane has a one-entry output register, so a stalled lane never corrupts another lane's data. It sits where a shared datapath fans back out to four consumers.

## Interface
- `WIDTH`, 8: data bits per beat.
- `clk` input 1: the single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an input beat is present.
- `in_ready` output 1: the block accepts the beat this cycle.
- `in_data` input WIDTH: beat payload.
- `in_sel` input 2: target lane; sampled only on a packet's first beat.
- `in_last` input 1: final beat of the packet.
- `out_valid` output 4: per-lane beat present.
- `out_ready` input 4: per-lane consumer ready.
- `out_data` output 4×WIDTH: per-lane payload; lane i is `out_data[i]`.
- `out_last` output 4: per-lane last flag.
- `busy` output 1: a multi-beat packet is in progress (FSM in BUSY).

## Operation
- Transfer rules:
  - Input transfer when `in_valid & in_ready`.
  - Lane i transfer when `out_valid[i] & out_ready[i]`.
- Target lane `tgt`:
  - In IDLE, `tgt = in_sel`.
  - In BUSY, `tgt = lock_sel`; `in_sel` is ignored.
- `in_ready = ~out_valid[tgt] | out_ready[tgt]`:
  - Lane empty, or draining in the same cycle, gives full throughput.
  - It depends only on the target lane; stalls on other lanes have no effect.
- Accepted beat: loads the `tgt` lane register with `{in_data, in_last}` and sets `out_valid[tgt]`.
- Lane drain without a refill in the same cycle: clears `out_valid[i]`. `out_data` and `out_last` hold their last value.
- Drain and refill of the same lane in the same cycle: the new beat loads and `out_valid` stays 1.
- FSM states IDLE and BUSY:
  - IDLE → BUSY on an accepted beat with `in_last=0`; `lock_sel <= in_sel`.
  - IDLE stays IDLE on an accepted beat with `in_last=1` (single-beat packet).
  - BUSY → IDLE on an accepted beat with `in_last=1`.
  - BUSY stays BUSY on an accepted beat with `in_last=0`, or when no beat is accepted.
- Beats within a packet are never reordered or split across lanes.
- Any lane may drain while the input targets a different lane.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `out_*[tgt]` after edge N. There is no combinational path from `in_data` to `out_data`.
- Sustained throughput is 1 beat/cycle per packet while the target lane's consumer holds `out_ready=1`.
- `in_ready` is combinational from `out_ready[tgt]`, `out_valid[tgt]`, state, and `in_sel` (in IDLE).
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, state IDLE, `lock_sel=0`, `busy=0`.
- After reset, `in_ready=1` because all lanes are empty.
- Reset asserted mid-packet:
  - The packet is abandoned and lane contents are discarded.
  - The next accepted beat after reset is treated as a first beat.
- `in_valid=0` while BUSY: state and lock are held indefinitely.
- A change of `in_sel` mid-packet has no effect.

## Structure
- Package `demux_pkg` holds:
  - `localparam NUM_LANES = 4`.
  - `typedef logic [1:0] lane_sel_t`.
  - `typedef enum logic {IDLE, BUSY} demux_state_t`.
- Sub-module `demux_lane_buf` (parameter WIDTH):
  - One-entry valid/ready register holding `{data, last}`.
  - Has `load` and `out_ready` inputs and a `full` output.
  - Instantiated NUM_LANES times via generate.
- Top level contains the FSM, `lock_sel` register, `tgt` select, and `in_ready` logic.

## Test plan
- Reset, then a single-beat packet (`sel=2`, data `0xA5`, `last=1`), all `out_ready=1`:
  - `out_valid=4'b0100` and `out_data[2]=0xA5` one cycle later.
  - `busy` stays 0.
- 3-beat packet with `sel=1` on the first beat and `in_sel` toggled to 3 on beats 2–3:
  - All three beats (`0x10`, `0x11`, `0x12`) appear on lane 1 only, in order.
  - `out_last[1]=1` only on `0x12`.
  - `busy` is 1 after beats 1 and 2 and 0 after beat 3.
- Lane 0 with `out_ready[0]=0` holding a beat, then a packet to lane 3:
  - `in_ready=1` and lane 3 delivers.
  - Lane 0 keeps its beat until `out_ready[0]` rises.
- Back-to-back beats to lane 2 with `out_ready[2]` pattern 1,0,0,1:
  - `in_ready` follows the stall.
  - No beat is lost or duplicated; 4 beats are received in order.
- `rst` asserted after beat 2 of a 4-beat packet to lane 1:
  - All `out_valid=0` and `busy=0`.
  - The next packet with `sel=0` routes to lane 0.
- Random traffic (1–8-beat packets, random `sel` and `out_ready`, 10k beats) checked against a scoreboard:
  - Per-lane ordering is preserved.
  - Packets are never interleaved within a lane.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-4 packet-aware stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } demux_state_t;

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry valid/ready output register holding a beat's {data, last}.
module demux_lane_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  // A load wins over a drain, so a same-cycle drain and refill stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      out_data <= in_data;
      out_last <= in_last;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_4.sv
// Packet-aware 1-to-4 stream demultiplexer: the lane is chosen on a packet's
// first beat and locked until its last beat; each lane has its own output register.
module demux_1_to_4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  lane_sel_t                          in_sel,
  input  logic                               in_last,
  output logic [NUM_LANES-1:0]               out_valid,
  input  logic [NUM_LANES-1:0]               out_ready,
  output logic [NUM_LANES-1:0][WIDTH-1:0]    out_data,
  output logic [NUM_LANES-1:0]               out_last,
  output logic                               busy
);

  demux_state_t          state, state_d;
  lane_sel_t             lock_sel, lock_sel_d;
  lane_sel_t             tgt;
  logic                  accept;
  logic [NUM_LANES-1:0]  load;

  // Mid-packet the locked lane is used and in_sel is ignored.
  always_comb begin
    tgt = (state == BUSY) ? lock_sel : in_sel;
  end

  assign in_ready = ~out_valid[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;
  assign busy     = (state == BUSY);

  always_comb begin
    load      = '0;
    load[tgt] = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else begin
      state    <= state_d;
      lock_sel <= lock_sel_d;
    end
  end

  // Single-beat packets never leave IDLE; only a non-last first beat locks a lane.
  always_comb begin
    state_d    = state;
    lock_sel_d = lock_sel;
    case (state)
      IDLE: begin
        if (accept && !in_last) begin
          state_d    = BUSY;
          lock_sel_d = in_sel;
        end
      end
      BUSY: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_buf #(
      .WIDTH (WIDTH)
    ) u_lane_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_ready (out_ready[i]),
      .full      (out_valid[i]),
      .out_data  (out_data[i]),
      .out_last  (out_last[i])
    );
  end

endmodule

// File: tb/tb_demux_1_to_4.sv
// Self-checking bench for demux_1_to_4: directed scenarios plus random packet
// traffic scored against per-lane expected-beat queues.
module tb_demux_1_to_4;
  import demux_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic                            clk;
  logic                            rst;
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                in_data;
  lane_sel_t                       in_sel;
  logic                            in_last;
  logic [NUM_LANES-1:0]            out_valid;
  logic [NUM_LANES-1:0]            out_ready;
  logic [NUM_LANES-1:0][WIDTH-1:0] out_data;
  logic [NUM_LANES-1:0]            out_last;
  logic                            busy;

  demux_1_to_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input lane_sel_t s, input logic l);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
  endtask

  // Expected beats {data, last} per lane, in delivery order.
  logic [WIDTH:0] exp_q [NUM_LANES][$];

  int        rdy_pat [4] = '{1, 0, 0, 1};
  int        sent, rcvd, r;
  logic      exp_rdy;
  int        beats_sent, cyc, left;
  logic      in_pkt, holding;
  lane_sel_t cur, tgt_m;
  logic [WIDTH:0] front;

  initial begin
    rst       = 1'b1;
    out_ready = 4'hF;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Single-beat packet to lane 2.
    drive(1'b1, 8'hA5, 2'd2, 1'b1);
    #1 check("single_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'b0100);
    check("single_data", 32'(out_data[2]), 32'hA5);
    check("single_last", 32'(out_last[2]), 32'h1);
    check("single_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    check("single_drained", 32'(out_valid), 32'h0);

    // 3-beat packet to lane 1; in_sel moves to 3 mid-packet.
    drive(1'b1, 8'h10, 2'd1, 1'b0);
    #1 check("pkt3_rdy0", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("pkt3_v0", 32'(out_valid), 32'b0010);
    check("pkt3_d0", 32'(out_data[1]), 32'h10);
    check("pkt3_l0", 32'(out_last[1]), 32'h0);
    check("pkt3_busy0", 32'(busy), 32'h1);
    drive(1'b1, 8'h11, 2'd3, 1'b0);
    #1 check("pkt3_rdy1", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("pkt3_v1", 32'(out_valid), 32'b0010);
    check("pkt3_d1", 32'(out_data[1]), 32'h11);
    check("pkt3_l1", 32'(out_last[1]), 32'h0);
    check("pkt3_busy1", 32'(busy), 32'h1);
    drive(1'b1, 8'h12, 2'd3, 1'b1);
    @(negedge clk);
    check("pkt3_v2", 32'(out_valid), 32'b0010);
    check("pkt3_d2", 32'(out_data[1]), 32'h12);
    check("pkt3_l2", 32'(out_last[1]), 32'h1);
    check("pkt3_busy2", 32'(busy), 32'h0);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    check("pkt3_drained", 32'(out_valid), 32'h0);

    // Lane 0 stalled while a packet goes to lane 3.
    out_ready = 4'b1110;
    drive(1'b1, 8'h30, 2'd0, 1'b1);
    @(negedge clk);
    check("stall_v0", 32'(out_valid), 32'b0001);
    check("stall_d0", 32'(out_data[0]), 32'h30);
    drive(1'b1, 8'h40, 2'd3, 1'b0);
    #1 check("stall_other_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("stall_v1", 32'(out_valid), 32'b1001);
    check("stall_d3a", 32'(out_data[3]), 32'h40);
    check("stall_busy", 32'(busy), 32'h1);
    drive(1'b1, 8'h41, 2'd0, 1'b1);
    #1 check("stall_lock_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("stall_v2", 32'(out_valid), 32'b1001);
    check("stall_d3b", 32'(out_data[3]), 32'h41);
    check("stall_l3b", 32'(out_last[3]), 32'h1);
    check("stall_d0_hold", 32'(out_data[0]), 32'h30);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    #1 check("stall_lane0_rdy", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("stall_v3", 32'(out_valid), 32'b0001);
    check("stall_d0_keep", 32'(out_data[0]), 32'h30);
    out_ready = 4'hF;
    @(negedge clk);
    check("stall_released", 32'(out_valid), 32'h0);

    // Back-to-back 4-beat packet to lane 2 with out_ready[2] = 1,0,0,1.
    sent = 0;
    rcvd = 0;
    for (int k = 0; k < 20 && rcvd < 4; k++) begin
      r = (k < 4) ? rdy_pat[k] : 1;
      out_ready = {1'b1, 1'(r), 2'b11};
      if (sent < 4) drive(1'b1, 8'(8'h50 + sent), 2'd2, (sent == 3));
      else          drive(1'b0, 8'h00, 2'd2, 1'b0);
      #1;
      exp_rdy = (sent == rcvd) || (r != 0);
      check("b2b_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("b2b_valid", 32'(out_valid[2]), 32'(sent != rcvd));
      if (sent != rcvd && r != 0) begin
        check("b2b_data", 32'(out_data[2]), 32'(8'(8'h50 + rcvd)));
        check("b2b_last", 32'(out_last[2]), 32'(rcvd == 3));
        rcvd++;
      end
      if (in_valid && exp_rdy) sent++;
      @(negedge clk);
    end
    check("b2b_count", 32'(rcvd), 32'd4);
    out_ready = 4'hF;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);

    // Reset in the middle of a 4-beat packet to lane 1.
    drive(1'b1, 8'h60, 2'd1, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h61, 2'd1, 1'b0);
    @(negedge clk);
    check("mid_rst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    #1 check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    drive(1'b1, 8'h70, 2'd0, 1'b1);
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'b0001);
    check("post_rst_data", 32'(out_data[0]), 32'h70);
    check("post_rst_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);

    // Random packets of 1..8 beats with random sel and per-lane backpressure.
    beats_sent = 0;
    cyc        = 0;
    left       = 0;
    in_pkt     = 1'b0;
    holding    = 1'b0;
    cur        = '0;
    while (beats_sent < 10000 && cyc < 60000) begin
      if (!holding) begin
        if ($urandom_range(0, 4) != 0) begin
          if (left == 0) left = $urandom_range(1, 8);
          drive(1'b1, 8'($urandom), 2'($urandom), (left == 1));
          holding = 1'b1;
        end else begin
          drive(1'b0, 8'($urandom), 2'($urandom), 1'b0);
        end
      end
      out_ready = 4'($urandom) | 4'($urandom);
      #1;
      tgt_m   = in_pkt ? cur : in_sel;
      exp_rdy = (exp_q[tgt_m].size() == 0) || out_ready[tgt_m];
      check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < NUM_LANES; i++) begin
        check("rnd_valid", 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0 && out_ready[i]) begin
          front = exp_q[i].pop_front();
          check("rnd_data", 32'(out_data[i]), 32'(front[WIDTH:1]));
          check("rnd_last", 32'(out_last[i]), 32'(front[0]));
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q[tgt_m].push_back({in_data, in_last});
        beats_sent++;
        left--;
        holding = 1'b0;
        if (in_last) in_pkt = 1'b0;
        else if (!in_pkt) begin
          in_pkt = 1'b1;
          cur    = in_sel;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("rnd_beat_count", 32'(beats_sent), 32'd10000);

    // Drain whatever is still buffered.
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    out_ready = 4'hF;
    #1;
    for (int i = 0; i < NUM_LANES; i++) begin
      check("drain_valid", 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
      if (exp_q[i].size() != 0) begin
        front = exp_q[i].pop_front();
        check("drain_data", 32'(out_data[i]), 32'(front[WIDTH:1]));
        check("drain_last", 32'(out_last[i]), 32'(front[0]));
      end
    end
    @(negedge clk);
    check("drain_empty", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
